bpu_update_queue: RTL and testbench

- Buffers resolved conditional-branch outcomes from the 2-wide commit stage.
- Drains them in order, one per cycle, into the bimodal base predictor's update port (update_valid / update_instr_info = {pc, taken}).
- Decouples the commit burst rate from the predictor's single update port; sits directly upstream of the base predictor's update path.

---
 rtl/bpu_pkg.sv | 21 ++
 rtl/bpu_update_queue.sv | 133 +++++++++++++
 tb/tb_bpu_update_queue.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bpu_pkg.sv
// Shared types for the bimodal predictor update path.
// The update payload is {pc, taken} with the taken bit in bit 0.
package bpu_pkg;

   localparam int unsigned BPU_PC_WIDTH = 32;
   localparam int unsigned TAKEN_BIT    = 0;

   typedef struct packed {
      logic [BPU_PC_WIDTH-1:0] pc;
      logic                    taken;
   } bpu_update_t;

   function automatic bpu_update_t mk_update(input logic [BPU_PC_WIDTH-1:0] pc,
                                             input logic                    taken);
      bpu_update_t u;
      u.pc    = pc;
      u.taken = taken;
      return u;
   endfunction

endpackage

// File: rtl/bpu_update_queue.sv
// In-order queue between the 2-wide commit stage and the single update port
// of the bimodal base predictor. Accepts up to two branches per cycle, drains one.
module bpu_update_queue
   import bpu_pkg::*;
#(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned PC_WIDTH  = 32,
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 commit_valid_i,
   input  logic [1:0]                 commit_is_cond_i,
   input  logic [2*PC_WIDTH-1:0]      commit_pc_i,
   input  logic [1:0]                 commit_taken_i,
   output logic                       commit_ready_o,
   output logic                       update_valid_o,
   output logic [PC_WIDTH:0]          update_instr_info_o,
   output logic [$clog2(DEPTH):0]     occupancy_o,
   output logic [CNT_WIDTH-1:0]       update_cnt_o
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned INFO_W = PC_WIDTH + 1;

   typedef logic [INFO_W-1:0] info_t;

   info_t                mem_q [DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_p1;
   logic [CNT_W-1:0]     count_q, count_d;
   logic                 upd_valid_q, upd_valid_d;
   info_t                upd_info_q, upd_info_d;
   logic [CNT_WIDTH-1:0] upd_cnt_q, upd_cnt_d;

   logic [1:0]           qual;
   logic                 ready;
   logic                 pop;
   logic [1:0]           n_push;
   logic                 we0, we1;
   info_t                slot0_info, slot1_info;
   info_t                wdata0, wdata1;

   // Entry layout follows the predictor: pc above the taken bit.
   always_comb begin
      slot0_info            = '0;
      slot1_info            = '0;
      slot0_info[TAKEN_BIT] = commit_taken_i[0];
      slot1_info[TAKEN_BIT] = commit_taken_i[1];
      slot0_info[INFO_W-1:1] = commit_pc_i[PC_WIDTH-1:0];
      slot1_info[INFO_W-1:1] = commit_pc_i[2*PC_WIDTH-1:PC_WIDTH];
   end

   assign qual      = commit_valid_i & commit_is_cond_i;
   assign ready     = (count_q <= CNT_W'(DEPTH - 2));
   assign pop       = (count_q != '0);
   assign wr_ptr_p1 = wr_ptr_q + PTR_W'(1);

   // Compact qualified slots so the older one always lands at wr_ptr.
   always_comb begin
      we0    = 1'b0;
      we1    = 1'b0;
      wdata0 = slot0_info;
      wdata1 = slot1_info;
      n_push = 2'd0;
      if (ready) begin
         unique case (qual)
            2'b11: begin
               we0    = 1'b1;
               we1    = 1'b1;
               n_push = 2'd2;
            end
            2'b01: begin
               we0    = 1'b1;
               n_push = 2'd1;
            end
            2'b10: begin
               we0    = 1'b1;
               wdata0 = slot1_info;
               n_push = 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Pointer, occupancy and registered update-port next state.
   always_comb begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d    = wr_ptr_q + PTR_W'(n_push);
      count_d     = count_q + CNT_W'(n_push) - CNT_W'(pop);
      upd_valid_d = pop;
      upd_info_d  = upd_info_q;
      upd_cnt_d   = upd_cnt_q;
      if (pop) begin
         upd_info_d = mem_q[rd_ptr_q];
         upd_cnt_d  = upd_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         upd_valid_q <= 1'b0;
         upd_info_q  <= '0;
         upd_cnt_q   <= '0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         upd_valid_q <= upd_valid_d;
         upd_info_q  <= upd_info_d;
         upd_cnt_q   <= upd_cnt_d;
      end
   end

   // Storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk) begin
      if (we0) mem_q[wr_ptr_q]  <= wdata0;
      if (we1) mem_q[wr_ptr_p1] <= wdata1;
   end

   assign commit_ready_o      = ready;
   assign update_valid_o      = upd_valid_q;
   assign update_instr_info_o = upd_info_q;
   assign occupancy_o         = count_q;
   assign update_cnt_o        = upd_cnt_q;

endmodule

// File: tb/tb_bpu_update_queue.sv
// Directed bench for bpu_update_queue: latency, ordering, filtering,
// backpressure at the full boundary, throughput and mid-run reset.
module tb_bpu_update_queue;

   localparam int unsigned DEPTH     = 8;
   localparam int unsigned PC_WIDTH  = 32;
   localparam int unsigned CNT_WIDTH = 32;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [1:0]                commit_valid_i = '0;
   logic [1:0]                commit_is_cond_i = '0;
   logic [2*PC_WIDTH-1:0]     commit_pc_i = '0;
   logic [1:0]                commit_taken_i = '0;
   logic                      commit_ready_o;
   logic                      update_valid_o;
   logic [PC_WIDTH:0]         update_instr_info_o;
   logic [$clog2(DEPTH):0]    occupancy_o;
   logic [CNT_WIDTH-1:0]      update_cnt_o;

   bpu_update_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .commit_valid_i      (commit_valid_i),
      .commit_is_cond_i    (commit_is_cond_i),
      .commit_pc_i         (commit_pc_i),
      .commit_taken_i      (commit_taken_i),
      .commit_ready_o      (commit_ready_o),
      .update_valid_o      (update_valid_o),
      .update_instr_info_o (update_instr_info_o),
      .occupancy_o         (occupancy_o),
      .update_cnt_o        (update_cnt_o)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [PC_WIDTH:0] got_q[$];
   int                got_cyc[$];
   int                cyc = 0;
   int                max_occ = 0;
   bit                ready_dropped = 1'b0;

   // Strobe recorder, sampled 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (update_valid_o) begin
         got_q.push_back(update_instr_info_o);
         got_cyc.push_back(cyc);
      end
      if (int'(occupancy_o) > max_occ) max_occ = int'(occupancy_o);
      if (!commit_ready_o) ready_dropped = 1'b1;
   end

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] c,
                        input logic [31:0] pc0, input logic t0,
                        input logic [31:0] pc1, input logic t1);
      commit_valid_i   = v;
      commit_is_cond_i = c;
      commit_pc_i      = {pc1, pc0};
      commit_taken_i   = {t1, t0};
   endtask

   task automatic idle();
      drive(2'b00, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      idle();
      #2 rst_n = 1'b0;
      #1;
      got_q.delete();
      got_cyc.delete();
      max_occ       = 0;
      ready_dropped = 1'b0;
      tick();
      @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic wait_strobes(input int n, input int budget);
      int guard = 0;
      while (got_q.size() < n && guard < budget) begin
         tick();
         guard++;
      end
   endtask

   function automatic logic [63:0] info(input logic [31:0] pc, input logic t);
      logic [PC_WIDTH:0] v;
      v = {pc, t};
      return 64'(v);
   endfunction

   initial begin
      int stalls;
      int guard;
      int seen;
      logic [31:0] pc;
      logic        tk;

      // Reset values
      do_reset();
      check_val("rst_valid", 64'(update_valid_o), 64'd0);
      check_val("rst_info",  64'(update_instr_info_o), 64'd0);
      check_val("rst_occ",   64'(occupancy_o), 64'd0);
      check_val("rst_cnt",   64'(update_cnt_o), 64'd0);
      check_val("rst_ready", 64'(commit_ready_o), 64'd1);

      // Single entry: accepted at E, strobe visible only after E+1
      drive(2'b01, 2'b01, 32'h1C000040, 1'b1, 32'h0, 1'b0);
      tick();
      idle();
      check_val("lat_e0_valid", 64'(update_valid_o), 64'd0);
      tick();
      check_val("lat_e1_valid", 64'(update_valid_o), 64'd1);
      check_val("lat_e1_info",  64'(update_instr_info_o), info(32'h1C000040, 1'b1));
      tick();
      check_val("lat_e2_valid", 64'(update_valid_o), 64'd0);
      check_val("lat_hold_info", 64'(update_instr_info_o), info(32'h1C000040, 1'b1));
      check_val("lat_cnt", 64'(update_cnt_o), 64'd1);

      // Dual push ordering
      do_reset();
      drive(2'b11, 2'b11, 32'h100, 1'b0, 32'h104, 1'b1);
      tick();
      idle();
      wait_strobes(2, 20);
      repeat (3) tick();
      check_val("dual_n", 64'(got_q.size()), 64'd2);
      if (got_q.size() >= 2) begin
         check_val("dual_0", 64'(got_q[0]), info(32'h100, 1'b0));
         check_val("dual_1", 64'(got_q[1]), info(32'h104, 1'b1));
         check_val("dual_b2b", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
      end
      check_val("dual_cnt", 64'(update_cnt_o), 64'd2);

      // Filtering: non-conditional slot dropped, slot-1-only group accepted
      do_reset();
      drive(2'b11, 2'b10, 32'h1F0, 1'b1, 32'h200, 1'b1);
      tick();
      drive(2'b10, 2'b10, 32'h0, 1'b0, 32'h300, 1'b0);
      tick();
      idle();
      wait_strobes(2, 20);
      repeat (3) tick();
      check_val("filt_n", 64'(got_q.size()), 64'd2);
      if (got_q.size() >= 2) begin
         check_val("filt_0", 64'(got_q[0]), info(32'h200, 1'b1));
         check_val("filt_1", 64'(got_q[1]), info(32'h300, 1'b0));
      end
      check_val("filt_cnt", 64'(update_cnt_o), 64'd2);

      // Backpressure: 8 dual groups, commit holds a group while ready is low
      do_reset();
      for (int g = 0; g < 8; g++) begin
         drive(2'b11, 2'b11, 32'h1000 + 32'(g * 8), 1'(g % 2), 32'h1004 + 32'(g * 8), 1'b1);
         guard = 0;
         while (!commit_ready_o && guard < 50) begin
            tick();
            guard++;
         end
         tick();
      end
      idle();
      wait_strobes(16, 60);
      repeat (3) tick();
      check_val("bp_n", 64'(got_q.size()), 64'd16);
      check_val("bp_ready_dropped", 64'(ready_dropped), 64'd1);
      check_val("bp_max_occ", 64'(max_occ), 64'd7);
      check_val("bp_cnt", 64'(update_cnt_o), 64'd16);
      check_val("bp_occ_end", 64'(occupancy_o), 64'd0);
      seen = (got_q.size() < 16) ? got_q.size() : 16;
      for (int i = 0; i < seen; i++) begin
         pc = 32'h1000 + 32'(i * 4);
         tk = (i % 2 == 1) ? 1'b1 : 1'(((i / 2) % 2));
         check_val($sformatf("bp_e%0d", i), 64'(got_q[i]), info(pc, tk));
      end

      // Sustained throughput: one qualified slot per cycle, alternating slots
      do_reset();
      stalls = 0;
      for (int i = 0; i < 50; i++) begin
         pc = 32'h4000 + 32'(i * 4);
         tk = (i % 3 == 0);
         if (i % 2 == 0) drive(2'b01, 2'b01, pc, tk, 32'h0, 1'b0);
         else            drive(2'b11, 2'b10, 32'hDEAD0000, 1'b1, pc, tk);
         if (!commit_ready_o) stalls++;
         tick();
      end
      idle();
      wait_strobes(50, 20);
      repeat (3) tick();
      check_val("sus_stalls", 64'(stalls), 64'd0);
      check_val("sus_n", 64'(got_q.size()), 64'd50);
      check_val("sus_cnt", 64'(update_cnt_o), 64'd50);
      if (got_q.size() == 50) begin
         check_val("sus_b2b", 64'(got_cyc[49] - got_cyc[0]), 64'd49);
         for (int i = 0; i < 50; i++) begin
            pc = 32'h4000 + 32'(i * 4);
            tk = (i % 3 == 0);
            check_val($sformatf("sus_e%0d", i), 64'(got_q[i]), info(pc, tk));
         end
      end

      // Mid-run reset with 5 entries queued
      do_reset();
      for (int g = 0; g < 4; g++) begin
         drive(2'b11, 2'b11, 32'h8000 + 32'(g * 8), 1'b1, 32'h8004 + 32'(g * 8), 1'b0);
         tick();
      end
      idle();
      check_val("mid_occ5", 64'(occupancy_o), 64'd5);
      #2 rst_n = 1'b0;
      #1;
      check_val("mid_rst_valid", 64'(update_valid_o), 64'd0);
      check_val("mid_rst_occ",   64'(occupancy_o), 64'd0);
      check_val("mid_rst_cnt",   64'(update_cnt_o), 64'd0);
      tick();
      #2 rst_n = 1'b1;
      tick();
      got_q.delete();
      repeat (10) tick();
      check_val("mid_no_strobe", 64'(got_q.size()), 64'd0);
      check_val("mid_occ_end",   64'(occupancy_o), 64'd0);
      check_val("mid_cnt_end",   64'(update_cnt_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
